// File: rtl/sdp_ram_arb_pkg.sv
// Shared types and helpers for the simple-dual-port RAM arbiter.
package sdp_ram_arb_pkg;

  // Requester id field is sized for the largest supported NUM_REQ (8).
  localparam int ID_W = 3;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_pend_t;

  function automatic int word_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, else lowest set request.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (IDX_W'(i) >= ptr);
    end
    hi_req = req & hi_mask;
    // Wrap to the low half only when nothing at or above the pointer is pending.
    pick = (|hi_req) ? hi_req : req;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
    any_grant = |req;
    grant     = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Round-robin sharing of one byte-write simple-dual-port RAM with same-word hazard masking.
// Define SDP_RAM_ARB_PERF_EN to add the perf_grant_cnt / perf_hazard_cnt counters.
module sdp_ram_arbiter
  import sdp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0]                      req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      req_address,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]    req_strb,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [DATA_WIDTH-1:0]                   rsp_data,
  output logic                                    ram_wr_enable,
  output logic [ADDR_WIDTH-1:0]                   ram_wr_address,
  output logic [DATA_WIDTH-1:0]                   ram_wr_data,
  output logic [DATA_WIDTH/8-1:0]                 ram_wr_strb,
  output logic [ADDR_WIDTH-1:0]                   ram_rd_address,
  input  logic [DATA_WIDTH-1:0]                   ram_rd_data
`ifdef SDP_RAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]                perf_grant_cnt,
  output logic [31:0]                             perf_hazard_cnt
`endif
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = word_lsb(DATA_WIDTH);
  localparam int WORD_W   = ADDR_WIDTH - ADDR_LSB;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  hz_valid_q, hz_valid_d;
  logic [WORD_W-1:0]     hz_word_q, hz_word_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0]     wr_strb_q, wr_strb_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  rd_pend_t              rd_pend0_q, rd_pend0_d;
  rd_pend_t              rd_pend1_q, rd_pend1_d;

  logic [NUM_REQ-1:0]    masked;
  logic [NUM_REQ-1:0]    eligible;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  op_e                   op;

  // Handshake: a transfer happens in the cycle req_valid[i] & req_ready[i]; ready is a
  // combinational one-hot grant, never depends on the requester dropping valid, and is
  // held low while rst is asserted.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = hz_valid_q && (req_address[i][ADDR_WIDTH-1:ADDR_LSB] == hz_word_q);
    end
    eligible = req_valid & ~masked & {NUM_REQ{~rst}};
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    hz_valid_d = 1'b0;
    hz_word_d  = hz_word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    rd_addr_d  = rd_addr_q;
    rd_pend0_d = '0;
    rd_pend1_d = rd_pend0_q;
    op         = op_e'(req_write[grant_idx]);
    if (any_grant) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      if (op == OP_WRITE) begin
        // An all-zero strobe completes the handshake but never reaches the RAM.
        if (|req_strb[grant_idx]) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = req_address[grant_idx];
          wr_data_d  = req_data[grant_idx];
          wr_strb_d  = req_strb[grant_idx];
          hz_valid_d = 1'b1;
          hz_word_d  = req_address[grant_idx][ADDR_WIDTH-1:ADDR_LSB];
        end
      end else begin
        rd_addr_d  = req_address[grant_idx];
        rd_pend0_d = '{valid: 1'b1, id: ID_W'(grant_idx)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      hz_valid_q <= 1'b0;
      hz_word_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rd_addr_q  <= '0;
      rd_pend0_q <= '0;
      rd_pend1_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      hz_valid_q <= hz_valid_d;
      hz_word_q  <= hz_word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rd_pend1_q.valid && (rd_pend1_q.id == ID_W'(i));
    end
  end

  assign rsp_data       = ram_rd_data;
  assign ram_wr_enable  = wr_en_q;
  assign ram_wr_address = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_strb    = wr_strb_q;
  assign ram_rd_address = rd_addr_q;

`ifdef SDP_RAM_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_cnt_q, perf_grant_cnt_d;
  logic [31:0]              perf_hazard_cnt_q, perf_hazard_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_grant_cnt_d  = perf_grant_cnt_q;
    perf_hazard_cnt_d = perf_hazard_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && (perf_grant_cnt_q[i] != '1)) begin
        perf_grant_cnt_d[i] = perf_grant_cnt_q[i] + 32'd1;
      end
    end
    if ((|(req_valid & masked)) && (perf_hazard_cnt_q != '1)) begin
      perf_hazard_cnt_d = perf_hazard_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_cnt_q  <= '0;
      perf_hazard_cnt_q <= '0;
    end else begin
      perf_grant_cnt_q  <= perf_grant_cnt_d;
      perf_hazard_cnt_q <= perf_hazard_cnt_d;
    end
  end

  assign perf_grant_cnt  = perf_grant_cnt_q;
  assign perf_hazard_cnt = perf_hazard_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Self-checking bench for sdp_ram_arbiter: directed scenarios plus random traffic,
// compared against a transaction-level model of grants, RAM contents and responses.
module tb_sdp_ram_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int AW      = 9;
  localparam int SW      = DW / 8;
  localparam int WORDS   = 1 << (AW - 1);

  logic                         clk;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           req_write;
  logic [NUM_REQ-1:0][AW-1:0]   req_address;
  logic [NUM_REQ-1:0][DW-1:0]   req_data;
  logic [NUM_REQ-1:0][SW-1:0]   req_strb;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DW-1:0]                rsp_data;
  logic                         ram_wr_enable;
  logic [AW-1:0]                ram_wr_address;
  logic [DW-1:0]                ram_wr_data;
  logic [SW-1:0]                ram_wr_strb;
  logic [AW-1:0]                ram_rd_address;
  logic [DW-1:0]                ram_rd_data;
`ifdef SDP_RAM_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0]     perf_grant_cnt;
  logic [31:0]                  perf_hazard_cnt;
`endif

  sdp_ram_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_data       (req_data),
    .req_strb       (req_strb),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .ram_wr_enable  (ram_wr_enable),
    .ram_wr_address (ram_wr_address),
    .ram_wr_data    (ram_wr_data),
    .ram_wr_strb    (ram_wr_strb),
    .ram_rd_address (ram_rd_address),
    .ram_rd_data    (ram_rd_data)
`ifdef SDP_RAM_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_hazard_cnt(perf_hazard_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM attached to the DUT ports ----------------
  logic [DW-1:0] tb_ram [WORDS];

  always @(posedge clk) begin
    logic [DW-1:0] w;
    ram_rd_data <= tb_ram[ram_rd_address[AW-1:1]];
    if (ram_wr_enable) begin
      w = tb_ram[ram_wr_address[AW-1:1]];
      for (int b = 0; b < SW; b++) begin
        if (ram_wr_strb[b]) w[8*b +: 8] = ram_wr_data[8*b +: 8];
      end
      tb_ram[ram_wr_address[AW-1:1]] <= w;
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_mem [WORDS];
  int            m_ptr;
  bit            m_hz_valid;
  int            m_hz_word;
  bit            m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [SW-1:0] m_wr_strb;
  logic [AW-1:0] m_rd_addr;
  bit            m_s0_valid, m_s1_valid;
  int            m_s0_id, m_s1_id;
  int            m_grants [NUM_REQ];
  int            m_hz_cycles;
  int            m_last_g;
  logic [DW-1:0] exp_q [$];

  logic [NUM_REQ-1:0] last_ready;
  logic               last_wr_en;
  logic [DW-1:0]      last_rsp_data;

  int checks;
  int errors;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a[AW-1:1]);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_hz_valid = 0; m_hz_word = 0;
    m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0; m_wr_strb = '0; m_rd_addr = '0;
    m_s0_valid = 0; m_s1_valid = 0; m_s0_id = 0; m_s1_id = 0;
    for (int i = 0; i < NUM_REQ; i++) m_grants[i] = 0;
    m_hz_cycles = 0; m_last_g = -1;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    req_valid = '0; req_write = '0; req_address = '0; req_data = '0; req_strb = '0;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = 1'b1; req_write[i] = wr; req_address[i] = a;
    req_data[i] = d; req_strb[i] = s;
  endtask

  // One clock cycle: check outputs at the negedge against the model, then advance it.
  task automatic step();
    int g;
    int w;
    bit any_masked;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rsp;
    logic [DW-1:0] d;
    @(negedge clk);
    g = -1; any_masked = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      w = word_of(req_address[i]);
      if (req_valid[i] && m_hz_valid && (w == m_hz_word)) any_masked = 1;
      else if (req_valid[i] && g < 0) g = i;
    end
    exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    last_ready = req_ready;
    last_wr_en = ram_wr_enable;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("ram_wr_enable", 64'(ram_wr_enable), 64'(m_wr_en));
    if (m_wr_en) begin
      check("ram_wr_address", 64'(ram_wr_address), 64'(m_wr_addr));
      check("ram_wr_data", 64'(ram_wr_data), 64'(m_wr_data));
      check("ram_wr_strb", 64'(ram_wr_strb), 64'(m_wr_strb));
    end
    check("ram_rd_address", 64'(ram_rd_address), 64'(m_rd_addr));
    exp_rsp = m_s1_valid ? (NUM_REQ'(1) << m_s1_id) : '0;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    if (m_s1_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL rsp_queue: observed=response expected=none_outstanding");
      end else begin
        d = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(d));
        last_rsp_data = rsp_data;
      end
    end
`ifdef SDP_RAM_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++) check("perf_grant_cnt", 64'(perf_grant_cnt[i]), 64'(m_grants[i]));
    check("perf_hazard_cnt", 64'(perf_hazard_cnt), 64'(m_hz_cycles));
`endif
    // advance model
    if (any_masked) m_hz_cycles++;
    m_s1_valid = m_s0_valid; m_s1_id = m_s0_id; m_s0_valid = 0;
    m_wr_en = 0; m_hz_valid = 0;
    m_last_g = g;
    if (g >= 0) begin
      m_grants[g]++;
      m_ptr = (g + 1) % NUM_REQ;
      w = word_of(req_address[g]);
      if (req_write[g]) begin
        if (req_strb[g] != '0) begin
          m_wr_en = 1; m_wr_addr = req_address[g]; m_wr_data = req_data[g]; m_wr_strb = req_strb[g];
          for (int b = 0; b < SW; b++) if (req_strb[g][b]) m_mem[w][8*b +: 8] = req_data[g][8*b +: 8];
          m_hz_valid = 1; m_hz_word = w;
        end
      end else begin
        m_s0_valid = 1; m_s0_id = g; m_rd_addr = req_address[g];
        exp_q.push_back(m_mem[w]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_ram_wr_enable"}, 64'(ram_wr_enable), 64'(0));
    check({tag, "_ram_wr_address"}, 64'(ram_wr_address), 64'(0));
    check({tag, "_ram_wr_data"}, 64'(ram_wr_data), 64'(0));
    check({tag, "_ram_wr_strb"}, 64'(ram_wr_strb), 64'(0));
    check({tag, "_ram_rd_address"}, 64'(ram_rd_address), 64'(0));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int fair_seq [5];
    logic [DW-1:0] v;
    checks = 0; errors = 0;
    fair_seq = '{0, 1, 2, 3, 0};
    for (int w = 0; w < WORDS; w++) begin
      v = DW'($urandom);
      tb_ram[w] = v;
      m_mem[w]  = v;
    end
    model_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // fairness: four held reads to distinct words
    set_req(0, 0, 9'h080, '0, '0);
    set_req(1, 0, 9'h0A0, '0, '0);
    set_req(2, 0, 9'h0C0, '0, '0);
    set_req(3, 0, 9'h0E0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("fair_grant", 64'(last_ready), 64'(NUM_REQ'(1) << fair_seq[k]));
    end
    idle();
    repeat (3) step();
    do_reset();

    // same-word write hazard
    set_req(0, 1, 9'h012, 16'h00AA, 2'b01);
    step();
    idle();
    set_req(1, 1, 9'h013, 16'hBB00, 2'b10);
    step();
    check("hz_blocked", 64'(last_ready), 64'(0));
    step();
    check("hz_late_grant", 64'(last_ready), 64'(4'b0010));
    idle();
    step();
    set_req(0, 0, 9'h012, '0, '0);
    step();
    check("hz_read_grant", 64'(last_ready), 64'(4'b0001));
    idle();
    repeat (3) step();
    check("hz_read_data", 64'(last_rsp_data), 64'(16'hBBAA));
`ifdef SDP_RAM_ARB_PERF_EN
    check("perf_hz_test_grant1", 64'(perf_grant_cnt[1]), 64'(1));
    check("perf_hz_test_hazard", 64'(perf_hazard_cnt), 64'(1));
`endif

    // read-after-write
    set_req(2, 1, 9'h040, 16'h1234, 2'b11);
    step();
    idle();
    set_req(3, 0, 9'h040, '0, '0);
    step();
    check("raw_blocked", 64'(last_ready), 64'(0));
    step();
    check("raw_grant", 64'(last_ready), 64'(4'b1000));
    idle();
    repeat (3) step();
    check("raw_data", 64'(last_rsp_data), 64'(16'h1234));

    // zero-strobe write
    set_req(1, 1, 9'h060, 16'hFFFF, 2'b00);
    step();
    check("zs_accept", 64'(last_ready), 64'(4'b0010));
    idle();
    set_req(0, 0, 9'h060, '0, '0);
    step();
    check("zs_no_wr_enable", 64'(last_wr_en), 64'(0));
    check("zs_read_grant", 64'(last_ready), 64'(4'b0001));
    idle();
    repeat (3) step();

    // randomized traffic over a small word set so hazards are frequent
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, 1'($urandom_range(0, 1)),
                  AW'((($urandom_range(0, 7) + 16) << 1) | $urandom_range(0, 1)),
                  DW'($urandom), SW'($urandom_range(0, 3)));
        end
      end
      step();
      if (m_last_g >= 0) req_valid[m_last_g] = 1'b0;
    end
    idle();
    repeat (3) step();
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    // reset one cycle after a read grant
    set_req(0, 0, 9'h0A0, '0, '0);
    step();
    check("mid_rd_grant", 64'(last_ready), 64'(4'b0001));
    set_req(1, 0, 9'h0C0, '0, '0);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle();
    repeat (3) step();
    set_req(0, 0, 9'h080, '0, '0);
    set_req(1, 0, 9'h0A0, '0, '0);
    set_req(2, 0, 9'h0C0, '0, '0);
    set_req(3, 0, 9'h0E0, '0, '0);
    step();
    check("post_reset_grant", 64'(last_ready), 64'(4'b0001));
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
